// File: rtl/rr_select_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_select_arbiter_pkg
//  Description : Shared constants for the round-robin decoder-select arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package rr_select_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;
    localparam int ST_W    = 2;

    localparam logic [ST_W-1:0] ST_IDLE  = 2'b00;
    localparam logic [ST_W-1:0] ST_GRANT = 2'b01;
    localparam logic [ST_W-1:0] ST_GAP   = 2'b10;

    typedef logic [SEL_W-1:0] sel_t;

endpackage : rr_select_arbiter_pkg
`default_nettype wire

// File: rtl/rr_select_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : rr_select_arbiter_if
//  Description : Request/release inputs and encoded decoder-select outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rr_select_arbiter_if;
    import rr_select_arbiter_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic               done;
    logic               sel1;
    logic               sel0;
    logic               valid;
    logic               timeout;

    modport master (
        output req, done,
        input  sel1, sel0, valid, timeout
    );

    modport slave (
        input  req, done,
        output sel1, sel0, valid, timeout
    );

endinterface : rr_select_arbiter_if
`default_nettype wire

// File: rtl/rr_select_arbiter_pick4.sv
`default_nettype none
// ============================================================================
//  Module      : rr_select_arbiter_pick4
//  Description : Combinational round-robin picker: first set request after ptr.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_select_arbiter_pick4
    import rr_select_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   idx
);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [SEL_W:0]       w_base;
    logic [NUM_REQ-1:0]   w_rot;
    logic [SEL_W-1:0]     w_off;

    // Rotate so bit 0 of w_rot is the requester right after ptr.
    assign w_dbl  = {req, req};
    assign w_base = {1'b0, ptr} + (SEL_W+1)'(1);
    assign w_rot  = w_dbl[w_base +: NUM_REQ];

    always_comb begin
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = SEL_W'(k);
            end
        end
    end

    assign any = |req;
    assign idx = ptr + SEL_W'(1) + w_off;

endmodule : rr_select_arbiter_pick4
`default_nettype wire

// File: rtl/rr_select_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_select_arbiter
//  Description : 4-way round-robin arbiter driving 2x4 decoder selects, with a
//                hold timer per grant and a dead gap between grants.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_select_arbiter
    import rr_select_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_select_arbiter_if.slave   bus
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(HOLD_MAX - 1);

    logic [ST_W-1:0]  r_state;
    logic [ST_W-1:0]  w_state_nxt;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] w_ptr_nxt;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] w_sel_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_timeout;
    logic             w_timeout_nxt;

    logic             w_any;
    logic [SEL_W-1:0] w_idx;
    logic             w_release;
    logic             w_expire;

    rr_select_arbiter_pick4 u_pick (
        .req (bus.req),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_idx)
    );

    // Release has priority over expiry, so a coincident done never times out.
    assign w_release = bus.done || !bus.req[r_sel];
    assign w_expire  = (r_cnt == c_cnt_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '1;
            r_sel     <= '0;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_sel     <= w_sel_nxt;
            r_cnt     <= w_cnt_nxt;
            r_valid   <= w_valid_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_IDLE:  w_state_nxt = w_any ? ST_GRANT : ST_IDLE;
            ST_GRANT: w_state_nxt = (w_release || w_expire) ? ST_GAP : ST_GRANT;
            ST_GAP:   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ptr_nxt     = r_ptr;
        w_sel_nxt     = r_sel;
        w_cnt_nxt     = '0;
        w_valid_nxt   = 1'b0;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_sel_nxt   = w_idx;
                    w_ptr_nxt   = w_idx;
                    w_valid_nxt = 1'b1;
                end
            end
            ST_GRANT: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (w_release) begin
                    w_valid_nxt = 1'b0;
                end else if (w_expire) begin
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_cnt_nxt = '0;
            end
        endcase
    end

    assign bus.sel1    = r_sel[1];
    assign bus.sel0    = r_sel[0];
    assign bus.valid   = r_valid;
    assign bus.timeout = r_timeout;

endmodule : rr_select_arbiter
`default_nettype wire

// File: tb/tb_rr_select_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_select_arbiter
//  Description : Randomized self-checking bench with a cycle-level reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_select_arbiter;

    localparam int HOLD = 8;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic [3:0] req  = '0;
    logic       done = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rr_select_arbiter_if bus();
    assign bus.req  = req;
    assign bus.done = done;

    rr_select_arbiter #(.HOLD_MAX(HOLD), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Downstream 2x4 decoder
    logic [3:0] dec_onehot;
    assign dec_onehot = 4'b0001 << {bus.sel1, bus.sel0};

    // Reference: grant age, post-grant cooldown edges and search pointer.
    bit         m_active  = 1'b0;
    int         m_age     = 0;
    int         m_cool    = 0;
    int         m_ptr     = 3;
    logic [1:0] m_sel     = '0;
    logic       m_valid   = 1'b0;
    logic       m_timeout = 1'b0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit rel;
        if (rst) begin
            m_active = 1'b0; m_age = 0; m_cool = 0; m_ptr = 3;
            m_sel = 2'b00; m_valid = 1'b0; m_timeout = 1'b0;
        end else if (m_active) begin
            rel = done || !req[m_sel];
            if (rel || m_age == HOLD) begin
                m_timeout = !rel;
                m_active  = 1'b0;
                m_valid   = 1'b0;
                m_cool    = 1;
            end else begin
                m_age++;
            end
        end else if (m_cool > 0) begin
            m_cool--;
            m_timeout = 1'b0;
        end else begin
            m_timeout = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                int i;
                i = (m_ptr + k) % 4;
                if (!m_active && req[i]) begin
                    m_active = 1'b1;
                    m_sel    = 2'(i);
                    m_ptr    = i;
                    m_age    = 1;
                    m_valid  = 1'b1;
                end
            end
        end
    endtask

    task automatic cyc(input logic r, input logic [3:0] q, input logic d);
        rst  = r;
        req  = q;
        done = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("outs", {4'b0, bus.valid, bus.sel1, bus.sel0, bus.timeout},
                    {4'b0, m_valid, m_sel, m_timeout});
        if (m_valid) begin
            chk("decoder", {4'b0, dec_onehot}, {4'b0, 4'b0001 << m_sel});
        end
    endtask

    initial begin
        logic [1:0] order_q[$];
        logic       pv;
        logic       seen_to;
        int         vlen;
        logic [3:0] rq;

        cyc(1'b1, 4'hf, 1'b0);
        cyc(1'b1, 4'hf, 1'b0);

        // Full request, each grant released one cycle after it rises
        pv = 1'b0;
        for (int c = 0; c < 60 && order_q.size() < 5; c++) begin
            cyc(1'b0, 4'hf, m_active && m_age == 1);
            if (bus.valid && !pv) order_q.push_back({bus.sel1, bus.sel0});
            pv = bus.valid;
        end
        chk("n_grants", 8'(order_q.size()), 8'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < order_q.size()) chk("order", {6'b0, order_q[i]}, 8'(i % 4));
        end

        // Single held request runs into the hold timer
        cyc(1'b1, 4'h0, 1'b0);
        seen_to = 1'b0;
        vlen    = 0;
        for (int c = 0; c < 30; c++) begin
            cyc(1'b0, 4'b0100, 1'b0);
            if (!seen_to) begin
                if (bus.valid) vlen++;
                if (bus.timeout) seen_to = 1'b1;
            end
        end
        chk("to_seen", {7'b0, seen_to}, 8'd1);
        chk("hold_len", 8'(vlen), 8'(HOLD));

        // Pointer after grant 0 skips 0 when others request
        cyc(1'b1, 4'hf, 1'b0);
        cyc(1'b0, 4'hf, 1'b0);
        cyc(1'b0, 4'b1001, 1'b1);
        cyc(1'b0, 4'b1001, 1'b0);
        cyc(1'b0, 4'b1001, 1'b0);
        chk("prio_sel", {5'b0, bus.valid, bus.sel1, bus.sel0}, 8'b0000_0111);

        // done on the final hold cycle suppresses the timeout
        cyc(1'b1, 4'h0, 1'b0);
        seen_to = 1'b0;
        for (int c = 0; c < 14; c++) begin
            cyc(1'b0, 4'b0010, m_active && m_age == HOLD);
            if (bus.timeout) seen_to = 1'b1;
        end
        chk("coinc_to", {7'b0, seen_to}, 8'd0);

        // Reset in the middle of a grant
        cyc(1'b1, 4'h0, 1'b0);
        cyc(1'b0, 4'b0100, 1'b0);
        cyc(1'b0, 4'b0100, 1'b0);
        chk("pre_rst", {5'b0, bus.valid, bus.sel1, bus.sel0}, 8'b0000_0110);
        cyc(1'b1, 4'hf, 1'b0);
        chk("mid_rst", {5'b0, bus.valid, bus.sel1, bus.sel0}, 8'd0);
        cyc(1'b0, 4'hf, 1'b0);
        chk("post_rst", {5'b0, bus.valid, bus.sel1, bus.sel0}, 8'b0000_0100);

        // Random traffic with slowly changing request vector
        rq = 4'hf;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 7) == 0) rq = 4'($urandom);
            cyc($urandom_range(0, 99) == 0, rq, $urandom_range(0, 5) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rr_select_arbiter
`default_nettype wire
